// File: rtl/traffic_light_controller_nway.sv
// traffic_light_controller_nway
// Round-robin controller for NUM_ROADS approaches at one intersection.
// Roads with zero demand are skipped. Green length is GREEN_BASE plus the
// road's demand sampled on the green entry edge. A latched pedestrian
// request inserts an all-red walk phase followed by a flashing clearance.
// All lamp outputs are registered and are computed from the next state, so
// they change on the same edge as the FSM state.
module traffic_light_controller_nway #(
  parameter int NUM_ROADS   = 4,
  parameter int IN_W        = 4,
  parameter int GREEN_BASE  = 4,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int WALK_TIME   = 6,
  parameter int FLASH_TIME  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_ROADS*IN_W-1:0]     road_in,
  input  logic                          ped_req,
  output logic [NUM_ROADS*3-1:0]        road_out,
  output logic [2:0]                    walk_way_out,
  output logic [$clog2(NUM_ROADS)-1:0]  active_road,
  output logic                          ped_pending
);

  localparam int RD_W  = $clog2(NUM_ROADS);
  // Longest load value is GREEN_BASE + (2^IN_W - 1) - 1; size for the full sum.
  localparam int TMR_W = $clog2(GREEN_BASE + (1 << IN_W));

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] WALK_DONT   = 3'b100;
  localparam logic [2:0] WALK_FLASH  = 3'b010;
  localparam logic [2:0] WALK_GO     = 3'b001;

  localparam logic [TMR_W-1:0] T_YELLOW = TMR_W'(YELLOW_TIME - 1);
  localparam logic [TMR_W-1:0] T_ALLRED = TMR_W'(ALLRED_TIME - 1);
  localparam logic [TMR_W-1:0] T_WALK   = TMR_W'(WALK_TIME - 1);
  localparam logic [TMR_W-1:0] T_FLASH  = TMR_W'(FLASH_TIME - 1);
  localparam logic [TMR_W-1:0] T_GBASE  = TMR_W'(GREEN_BASE - 1);
  localparam logic [RD_W-1:0]  LAST_ROAD = RD_W'(NUM_ROADS - 1);

  typedef enum logic [2:0] {
    ST_ALLRED = 3'd0,
    ST_GREEN  = 3'd1,
    ST_YELLOW = 3'd2,
    ST_WALK   = 3'd3,
    ST_FLASH  = 3'd4
  } state_t;

  state_t                   state_r, state_nxt_s;
  logic [TMR_W-1:0]         timer_r, timer_nxt_s;
  logic [RD_W-1:0]          active_r, active_nxt_s;
  logic                     ped_r, ped_nxt_s;
  // Set when a walk phase has just finished: the following all-red gives
  // waiting traffic precedence over a request queued during that walk.
  logic                     walk_served_r, walk_served_nxt_s;
  logic                     enter_walk_s;
  logic                     found_s;
  logic [RD_W-1:0]          found_idx_s;
  logic [IN_W-1:0]          found_dem_s;
  logic [NUM_ROADS*3-1:0]   road_out_r, road_out_nxt_s;
  logic [2:0]               walk_r, walk_nxt_s;

  // Round-robin search for the next road with demand, starting after active_r.
  always_comb begin
    int idx_v;
    found_s     = 1'b0;
    found_idx_s = {RD_W{1'b0}};
    found_dem_s = {IN_W{1'b0}};
    idx_v       = 0;
    for (int i = 1; i <= NUM_ROADS; i++) begin
      idx_v = (int'(active_r) + i) % NUM_ROADS;
      if (!found_s && (road_in[idx_v*IN_W +: IN_W] != {IN_W{1'b0}})) begin
        found_s     = 1'b1;
        found_idx_s = RD_W'(idx_v);
        found_dem_s = road_in[idx_v*IN_W +: IN_W];
      end else begin
        found_s     = found_s;
      end
    end
  end

  // Next-state, phase timer, active road and pedestrian latch.
  always_comb begin
    state_nxt_s       = state_r;
    timer_nxt_s       = timer_r;
    active_nxt_s      = active_r;
    walk_served_nxt_s = walk_served_r;
    enter_walk_s      = 1'b0;
    case (state_r)
      ST_ALLRED: begin
        if (timer_r != {TMR_W{1'b0}}) begin
          timer_nxt_s = timer_r - TMR_W'(1);
        end else if (ped_r && !(walk_served_r && found_s)) begin
          state_nxt_s  = ST_WALK;
          timer_nxt_s  = T_WALK;
          enter_walk_s = 1'b1;
        end else if (found_s) begin
          state_nxt_s       = ST_GREEN;
          active_nxt_s      = found_idx_s;
          timer_nxt_s       = T_GBASE + TMR_W'(found_dem_s);
          walk_served_nxt_s = 1'b0;
        end else begin
          // Idle: timer parked at zero so the decision repeats every cycle.
          timer_nxt_s = {TMR_W{1'b0}};
        end
      end
      ST_GREEN: begin
        if (timer_r == {TMR_W{1'b0}}) begin
          state_nxt_s = ST_YELLOW;
          timer_nxt_s = T_YELLOW;
        end else begin
          timer_nxt_s = timer_r - TMR_W'(1);
        end
      end
      ST_YELLOW: begin
        if (timer_r == {TMR_W{1'b0}}) begin
          state_nxt_s = ST_ALLRED;
          timer_nxt_s = T_ALLRED;
        end else begin
          timer_nxt_s = timer_r - TMR_W'(1);
        end
      end
      ST_WALK: begin
        if (timer_r == {TMR_W{1'b0}}) begin
          state_nxt_s = ST_FLASH;
          timer_nxt_s = T_FLASH;
        end else begin
          timer_nxt_s = timer_r - TMR_W'(1);
        end
      end
      ST_FLASH: begin
        if (timer_r == {TMR_W{1'b0}}) begin
          state_nxt_s       = ST_ALLRED;
          timer_nxt_s       = T_ALLRED;
          walk_served_nxt_s = 1'b1;
        end else begin
          timer_nxt_s = timer_r - TMR_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_ALLRED;
        timer_nxt_s = T_ALLRED;
      end
    endcase

    // A press on the walk entry edge wins over the clear and queues another walk.
    if (ped_req) begin
      ped_nxt_s = 1'b1;
    end else if (enter_walk_s) begin
      ped_nxt_s = 1'b0;
    end else begin
      ped_nxt_s = ped_r;
    end
  end

  // Lamp decode from the next state so the registered outputs track the FSM.
  always_comb begin
    road_out_nxt_s = {NUM_ROADS{LAMP_RED}};
    walk_nxt_s     = WALK_DONT;
    for (int k = 0; k < NUM_ROADS; k++) begin
      if (active_nxt_s == RD_W'(k)) begin
        case (state_nxt_s)
          ST_GREEN:  road_out_nxt_s[k*3 +: 3] = LAMP_GREEN;
          ST_YELLOW: road_out_nxt_s[k*3 +: 3] = LAMP_YELLOW;
          default:   road_out_nxt_s[k*3 +: 3] = LAMP_RED;
        endcase
      end else begin
        road_out_nxt_s[k*3 +: 3] = LAMP_RED;
      end
    end
    case (state_nxt_s)
      ST_WALK:  walk_nxt_s = WALK_GO;
      ST_FLASH: walk_nxt_s = WALK_FLASH;
      default:  walk_nxt_s = WALK_DONT;
    endcase
  end

  // State, timer and output registers with synchronous reset to all-red.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_ALLRED;
      timer_r       <= T_ALLRED;
      active_r      <= LAST_ROAD;
      ped_r         <= 1'b0;
      walk_served_r <= 1'b0;
      road_out_r    <= {NUM_ROADS{LAMP_RED}};
      walk_r        <= WALK_DONT;
    end else begin
      state_r       <= state_nxt_s;
      timer_r       <= timer_nxt_s;
      active_r      <= active_nxt_s;
      ped_r         <= ped_nxt_s;
      walk_served_r <= walk_served_nxt_s;
      road_out_r    <= road_out_nxt_s;
      walk_r        <= walk_nxt_s;
    end
  end

  assign road_out     = road_out_r;
  assign walk_way_out = walk_r;
  assign active_road  = active_r;
  assign ped_pending  = ped_r;

endmodule

// File: tb/tb_traffic_light_controller_nway.sv
// tb_traffic_light_controller_nway
// Directed bench for the N-way traffic light controller with default
// parameters. Each phase is described by its expected lamp pattern and
// length in cycles; outputs are sampled 1 time unit after each rising edge.
module tb_traffic_light_controller_nway;

  localparam int NR = 4;
  localparam int IW = 4;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] DW  = 3'b100;
  localparam logic [2:0] FLS = 3'b010;
  localparam logic [2:0] WLK = 3'b001;

  logic               clk;
  logic               rst;
  logic [NR*IW-1:0]   road_in;
  logic               ped_req;
  logic [NR*3-1:0]    road_out;
  logic [2:0]         walk_way_out;
  logic [1:0]         active_road;
  logic               ped_pending;

  int vec_cnt = 0;
  int err_cnt = 0;

  traffic_light_controller_nway #(
    .NUM_ROADS(NR), .IN_W(IW), .GREEN_BASE(4), .YELLOW_TIME(2),
    .ALLRED_TIME(1), .WALK_TIME(6), .FLASH_TIME(3)
  ) dut (
    .clk(clk), .rst(rst), .road_in(road_in), .ped_req(ped_req),
    .road_out(road_out), .walk_way_out(walk_way_out),
    .active_road(active_road), .ped_pending(ped_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports miscompares.
  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR*3-1:0] lamps(input int road, input logic [2:0] col);
    logic [NR*3-1:0] l;
    for (int k = 0; k < NR; k++) l[k*3 +: 3] = (k == road) ? col : RED;
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check n consecutive cycles against one expected phase, advancing a clock each.
  task automatic run_phase(input string tag, input int road, input logic [2:0] col,
                           input logic [2:0] walk, input int act, input logic ped, input int n);
    for (int c = 0; c < n; c++) begin
      check_vec($sformatf("%s.lamps[%0d]", tag, c), 32'(road_out), 32'(lamps(road, col)));
      check_vec($sformatf("%s.walk[%0d]", tag, c), 32'(walk_way_out), 32'(walk));
      check_vec($sformatf("%s.active[%0d]", tag, c), 32'(active_road), 32'(act));
      check_vec($sformatf("%s.ped[%0d]", tag, c), 32'(ped_pending), 32'(ped));
      tick();
    end
  endtask

  // One full service of a road: green, two yellow, one all-red.
  task automatic serve(input string tag, input int road, input int glen, input logic ped);
    run_phase({tag, ".green"}, road, GRN, DW, road, ped, glen);
    run_phase({tag, ".yellow"}, road, YEL, DW, road, ped, 2);
    run_phase({tag, ".allred"}, -1, RED, DW, road, ped, 1);
  endtask

  task automatic do_reset(input logic [NR*IW-1:0] dem);
    road_in = dem;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    ped_req = 1'b0;
    road_in = 16'hA73F;

    // Basic rotation: demands A=F, B=3, C=7, D=A.
    repeat (10) tick();
    rst = 1'b0;
    run_phase("t1.rst", -1, RED, DW, 3, 1'b0, 1);
    serve("t1.r0", 0, 19, 1'b0);
    serve("t1.r1", 1, 7, 1'b0);
    serve("t1.r2", 2, 11, 1'b0);
    serve("t1.r3", 3, 14, 1'b0);
    serve("t1.r0b", 0, 19, 1'b0);

    // Road 1 without demand is skipped.
    do_reset(16'hA70F);
    run_phase("t2.rst", -1, RED, DW, 3, 1'b0, 1);
    serve("t2.r0", 0, 19, 1'b0);
    serve("t2.r2", 2, 11, 1'b0);
    serve("t2.r3", 3, 14, 1'b0);
    serve("t2.r0b", 0, 19, 1'b0);

    // Pedestrian pulse during road 0 green.
    do_reset(16'hA73F);
    run_phase("t3.rst", -1, RED, DW, 3, 1'b0, 1);
    ped_req = 1'b1;
    run_phase("t3.g0a", 0, GRN, DW, 0, 1'b0, 1);
    ped_req = 1'b0;
    run_phase("t3.g0b", 0, GRN, DW, 0, 1'b1, 18);
    run_phase("t3.y0", 0, YEL, DW, 0, 1'b1, 2);
    run_phase("t3.ar0", -1, RED, DW, 0, 1'b1, 1);
    run_phase("t3.walk", -1, RED, WLK, 0, 1'b0, 6);
    run_phase("t3.flash", -1, RED, FLS, 0, 1'b0, 3);
    run_phase("t3.arw", -1, RED, DW, 0, 1'b0, 1);
    run_phase("t3.g1", 1, GRN, DW, 1, 1'b0, 7);

    // Idle with no demand, then road 2 gets demand 2.
    do_reset(16'h0000);
    run_phase("t4.idle", -1, RED, DW, 3, 1'b0, 20);
    road_in = 16'h0200;
    run_phase("t4.wake", -1, RED, DW, 3, 1'b0, 1);
    serve("t4.r2", 2, 6, 1'b0);
    run_phase("t4.r2b", 2, GRN, DW, 2, 1'b0, 6);

    // Reset mid-green of road 1 with a pedestrian request latched.
    do_reset(16'hA73F);
    run_phase("t5.rst", -1, RED, DW, 3, 1'b0, 1);
    serve("t5.r0", 0, 19, 1'b0);
    ped_req = 1'b1;
    run_phase("t5.g1a", 1, GRN, DW, 1, 1'b0, 1);
    ped_req = 1'b0;
    run_phase("t5.g1b", 1, GRN, DW, 1, 1'b1, 2);
    rst = 1'b1;
    run_phase("t5.g1c", 1, GRN, DW, 1, 1'b1, 1);
    rst = 1'b0;
    run_phase("t5.abort", -1, RED, DW, 3, 1'b0, 1);
    run_phase("t5.g0", 0, GRN, DW, 0, 1'b0, 19);

    // Only road 3 has demand 1.
    do_reset(16'h1000);
    run_phase("t6.rst", -1, RED, DW, 3, 1'b0, 1);
    serve("t6.a", 3, 5, 1'b0);
    serve("t6.b", 3, 5, 1'b0);
    serve("t6.c", 3, 5, 1'b0);

    // Pedestrian with no traffic, plus a request made during the walk.
    do_reset(16'h0000);
    run_phase("t7.rst", -1, RED, DW, 3, 1'b0, 1);
    ped_req = 1'b1;
    run_phase("t7.press", -1, RED, DW, 3, 1'b0, 1);
    ped_req = 1'b0;
    run_phase("t7.latched", -1, RED, DW, 3, 1'b1, 1);
    run_phase("t7.walka", -1, RED, WLK, 3, 1'b0, 2);
    ped_req = 1'b1;
    run_phase("t7.walkb", -1, RED, WLK, 3, 1'b0, 1);
    ped_req = 1'b0;
    run_phase("t7.walkc", -1, RED, WLK, 3, 1'b1, 3);
    run_phase("t7.flash", -1, RED, FLS, 3, 1'b1, 3);
    run_phase("t7.ar", -1, RED, DW, 3, 1'b1, 1);
    run_phase("t7.walk2", -1, RED, WLK, 3, 1'b0, 6);
    run_phase("t7.flash2", -1, RED, FLS, 3, 1'b0, 3);
    run_phase("t7.idle", -1, RED, DW, 3, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/traffic_light_controller_nway.md
Name: traffic_light_controller_nway

Overview:
Parametrised successor to the fixed 4-way traffic light controller. It serves NUM_ROADS approaches in round-robin order and skips any approach with zero demand. Green time scales with each road's sampled demand value. A latched pedestrian request inserts an all-road-red walk phase with a flashing clearance. The block sits between the road sensor/density inputs and the lamp drivers at one intersection.

Parameters:
NUM_ROADS, 4, number of approaches (2..8)
IN_W, 4, width of each road's demand value
GREEN_BASE, 4, minimum green cycles; green = GREEN_BASE + demand
YELLOW_TIME, 2, yellow cycles
ALLRED_TIME, 1, all-red clearance cycles after each yellow or walk phase
WALK_TIME, 6, steady walk cycles
FLASH_TIME, 3, flashing don't-walk cycles
(all time parameters >= 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
road_in  in  NUM_ROADS*IN_W  per-road demand; road k at bits [k*IN_W +: IN_W]; 0 = no demand
ped_req  in  1  pedestrian button, level or pulse
road_out  out  NUM_ROADS*3  per-road lamp at bits [k*3 +: 3]: 3'b100 red, 3'b010 yellow, 3'b001 green
walk_way_out  out  3  3'b100 don't-walk, 3'b010 flashing, 3'b001 walk
active_road  out  $clog2(NUM_ROADS)  index of the road last or currently granted green
ped_pending  out  1  latched pedestrian request

Behaviour:
- Single clock domain. Reset is synchronous and active-high: rst sampled high at a clk edge puts the block in reset state on that edge.
- Reset state: all road_out = 3'b100; walk_way_out = 3'b100; ped_pending = 0; active_road = NUM_ROADS-1; FSM = ALLRED with timer loaded for ALLRED_TIME. Reset asserted mid-phase aborts the phase on the same edge, with no yellow.
- FSM states: ALLRED, GREEN, YELLOW, WALK, FLASH. On entry to a state, the down-counter timer is loaded with duration-1. The FSM leaves the state on the edge where timer==0, so each state lasts exactly its duration in cycles.
- Timer width: enough bits for GREEN_BASE + 2^IN_W - 1.
- GREEN: only road active_road = 3'b001; all others red. Duration = GREEN_BASE + road_in[active_road], sampled on the entry edge. Demand changes during green have no effect. Next state: YELLOW.
- YELLOW: active road = 3'b010. Next state: ALLRED.
- WALK: all roads red, walk_way_out = 3'b001. Next state: FLASH. FLASH: walk_way_out = 3'b010. Next state: ALLRED.
- Outside WALK and FLASH, walk_way_out = 3'b100.
- ALLRED exit decision, taken on the edge where timer==0, in priority order:
  1. If ped_pending=1, go to WALK.
  2. Otherwise, search roads active_road+1, +2, ... modulo NUM_ROADS, ending with active_road itself. Take the first road with road_in != 0: active_road <= that road, enter GREEN.
  3. If no demand and no ped request, stay in ALLRED (idle). The timer holds at 0 and the decision repeats every cycle, so green begins on the edge after demand appears.
- ped_pending: set on any clk edge with ped_req=1; cleared on the WALK entry edge. If ped_req=1 on the WALK entry edge, set wins and a further walk is queued. A request made during WALK or FLASH is served after the next green phase, unless no road has demand, in which case it is served immediately.
- Safety invariant: at most one road is non-red in any cycle. No road is non-red while walk_way_out != 3'b100.

Test Plan:
- Defaults, road_in = {D=A, C=7, B=3, A=F}, rst high 10 cycles then low -> 1 cycle all-red. Then road0 green 19, yellow 2, red 1; road1 green 7; road2 green 11; road3 green 14; the sequence repeats. Never two roads non-red.
- road_in B=0 and others nonzero -> after road0's all-red, road2 goes green directly; road1 stays 3'b100 throughout.
- 1-cycle ped_req pulse during road0 green -> ped_pending=1. After road0 yellow and all-red: walk 6 cycles, flash 3, all-red 1, then road1 green. ped_pending clears on the WALK entry edge.
- All road_in=0 and no ped_req -> all red and don't-walk indefinitely. Set C=2 -> road2 green on the next edge, for 6 cycles.
- rst asserted for 1 cycle mid-green of road1 -> next edge all red and don't-walk, ped_pending=0. After ALLRED, road0 is served first.
- Only road3 has demand (value 1) -> road3 repeats green 5, yellow 2, red 1; active_road stays 3.
